// File: rtl/obs_l4_mult_sched_163bit.sv
// -----------------------------------------------------------------------------
// obs_l4_mult_sched_163bit
//
// Purpose:
//   Schedules one unreduced GF(2^163) polynomial multiply a*b through a single
//   shared 82x82 carry-less sub-multiplier. Each operand is split into its
//   even and odd coefficient halves. The four half-products are issued one at
//   a time, in the order ae*be, ae*bo, ao*be, ao*bo, and each product is held
//   in its own register. The registered products drive the external level-4
//   overlap stage. Its 327-bit output is captured and returned with a
//   valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   start, a_in, b_in     request plus operands (accepted only when busy=0)
//   busy                  high while an operation is in flight
//   sm_valid/sm_ready     operand handshake to the shared sub-multiplier
//   sm_a, sm_b            sub-multiplier operand halves
//   sm_rvalid, sm_p       single-cycle product return from the sub-multiplier
//   ov_in1..ov_in4        registered half-products P1..P4 to the overlap stage
//   ov_out                combinational overlap-stage result
//   res_valid/res_ready   result handshake
//   result                captured product a*b
//
// Optional feature (macro OBS_SKIP_ZERO_EN):
//   When this macro is defined, a half-product is skipped if either operand
//   half is all-zero. Its P register is loaded with 0 and k advances in one
//   cycle, without a sub-multiplier transaction.
//
// States:
//   IDLE    | waiting for start
//   ISSUE   | presenting half pair k to the sub-multiplier
//   WAIT    | one transaction outstanding, waiting for sm_rvalid
//   COMBINE | capturing the overlap-stage output into result
//   OUT     | result valid, waiting for res_ready
// -----------------------------------------------------------------------------
module obs_l4_mult_sched_163bit #(
    parameter int M  = 163,
    parameter int H  = 82,
    parameter int PW = 163,
    parameter int RW = 327
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [M-1:0]  a_in,
    input  logic [M-1:0]  b_in,
    output logic          busy,
    output logic          sm_valid,
    input  logic          sm_ready,
    output logic [H-1:0]  sm_a,
    output logic [H-1:0]  sm_b,
    input  logic          sm_rvalid,
    input  logic [PW-1:0] sm_p,
    output logic [PW-1:0] ov_in1,
    output logic [PW-1:0] ov_in2,
    output logic [PW-1:0] ov_in3,
    output logic [PW-1:0] ov_in4,
    input  logic [RW-1:0] ov_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMBINE,
        S_OUT
    } state_t;

    state_t        state, state_nxt;
    logic [M-1:0]  a_q, b_q;
    logic [1:0]    k;
    logic [PW-1:0] p1_q, p2_q, p3_q, p4_q;
    logic [RW-1:0] res_q;

    logic [H-1:0]  ae, ao, be, bo;
    logic [H-1:0]  sel_a, sel_b;
    logic          skip;

    logic          latch_ops;
    logic          cap;
    logic          cap_zero;
    logic          adv_k;
    logic          load_res;
    logic [PW-1:0] cap_data;

    // Even/odd coefficient split. The odd halves have only H-1 meaningful
    // bits, so their top bit remains zero.
    always_comb begin
        ae = '0;
        ao = '0;
        be = '0;
        bo = '0;
        for (int i = 0; i < H; i++) begin
            ae[i] = a_q[2*i];
            be[i] = b_q[2*i];
        end
        for (int i = 0; i < H - 1; i++) begin
            ao[i] = a_q[2*i+1];
            bo[i] = b_q[2*i+1];
        end
    end

    // k[1] selects the a half and k[0] selects the b half:
    // 0 -> ae*be, 1 -> ae*bo, 2 -> ao*be, 3 -> ao*bo.
    assign sel_a = k[1] ? ao : ae;
    assign sel_b = k[0] ? bo : be;

`ifdef OBS_SKIP_ZERO_EN
    assign skip = (state == S_ISSUE) && ((sel_a == '0) || (sel_b == '0));
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        latch_ops = 1'b0;
        cap       = 1'b0;
        cap_zero  = 1'b0;
        adv_k     = 1'b0;
        load_res  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch_ops = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (skip) begin
                    cap      = 1'b1;
                    cap_zero = 1'b1;
                    if (k == 2'd3) begin
                        state_nxt = S_COMBINE;
                    end else begin
                        adv_k = 1'b1;
                    end
                end else if (sm_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sm_rvalid) begin
                    cap = 1'b1;
                    if (k == 2'd3) begin
                        state_nxt = S_COMBINE;
                    end else begin
                        adv_k     = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_COMBINE: begin
                load_res  = 1'b1;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign cap_data = cap_zero ? '0 : sm_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            k     <= '0;
            p1_q  <= '0;
            p2_q  <= '0;
            p3_q  <= '0;
            p4_q  <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (latch_ops) begin
                a_q <= a_in;
                b_q <= b_in;
                k   <= 2'd0;
            end
            if (adv_k) begin
                k <= k + 2'd1;
            end
            if (cap) begin
                case (k)
                    2'd0:    p1_q <= cap_data;
                    2'd1:    p2_q <= cap_data;
                    2'd2:    p3_q <= cap_data;
                    default: p4_q <= cap_data;
                endcase
            end
            if (load_res) begin
                res_q <= ov_out;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign sm_valid  = (state == S_ISSUE) && !skip;
    assign sm_a      = (state == S_ISSUE) ? sel_a : '0;
    assign sm_b      = (state == S_ISSUE) ? sel_b : '0;
    assign res_valid = (state == S_OUT);
    assign result    = res_q;
    assign ov_in1    = p1_q;
    assign ov_in2    = p2_q;
    assign ov_in3    = p3_q;
    assign ov_in4    = p4_q;

endmodule

// File: tb/tb_obs_l4_mult_sched_163bit.sv
// -----------------------------------------------------------------------------
// tb_obs_l4_mult_sched_163bit
//
// Purpose:
//   Directed bench for obs_l4_mult_sched_163bit. It models the shared
//   sub-multiplier with a configurable latency, optional sm_ready stalls, and
//   the overlap stage. It checks the results against hand-computed constants
//   and against a plain carry-less reference multiply.
// -----------------------------------------------------------------------------
module tb_obs_l4_mult_sched_163bit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [162:0] a_in, b_in;
    logic         busy;
    logic         sm_valid;
    logic         sm_ready;
    logic [81:0]  sm_a, sm_b;
    logic         sm_rvalid;
    logic [162:0] sm_p;
    logic [162:0] ov_in1, ov_in2, ov_in3, ov_in4;
    logic [326:0] ov_out;
    logic         res_valid;
    logic         res_ready;
    logic [326:0] result;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obs_l4_mult_sched_163bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .sm_valid  (sm_valid),
        .sm_ready  (sm_ready),
        .sm_a      (sm_a),
        .sm_b      (sm_b),
        .sm_rvalid (sm_rvalid),
        .sm_p      (sm_p),
        .ov_in1    (ov_in1),
        .ov_in2    (ov_in2),
        .ov_in3    (ov_in3),
        .ov_in4    (ov_in4),
        .ov_out    (ov_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result)
    );

    function automatic logic [162:0] clmul82(input logic [81:0] x, input logic [81:0] y);
        logic [162:0] r;
        r = '0;
        for (int i = 0; i < 82; i++) begin
            if (y[i]) r = r ^ ({81'b0, x} << i);
        end
        return r;
    endfunction

    function automatic logic [326:0] ref_mul(input logic [162:0] x, input logic [162:0] y);
        logic [326:0] r;
        r = '0;
        for (int i = 0; i < 163; i++) begin
            if (y[i]) r = r ^ ({164'b0, x} << i);
        end
        return r;
    endfunction

    // Overlap stage: a*b = P1(x^2) + x*(P2+P3)(x^2) + x^2*P4(x^2)
    always_comb begin
        ov_out = '0;
        for (int i = 0; i < 163; i++) begin
            ov_out[2*i]   = ov_in1[i];
            ov_out[2*i+1] = ov_in2[i] ^ ov_in3[i];
        end
        for (int i = 0; i < 163; i++) begin
            ov_out[2*i+2] = ov_out[2*i+2] ^ ov_in4[i];
        end
    end

    // Sub-multiplier model. A product issued at edge E is visible as
    // sm_rvalid in the cycle that is sampled at edge E+L. The model ignores rst_n.
    int           lat_min = 1;
    int           lat_max = 1;
    int           sm_cnt  = 0;
    int           hs_cnt  = 0;
    logic [162:0] pend    = '0;

    always @(posedge clk) begin
        if (sm_cnt != 0) sm_cnt <= sm_cnt - 1;
        if (sm_valid && sm_ready) begin
            pend   <= clmul82(sm_a, sm_b);
            sm_cnt <= int'($urandom_range(lat_max, lat_min));
            hs_cnt <= hs_cnt + 1;
        end
    end
    assign sm_rvalid = (sm_cnt == 1);
    assign sm_p      = pend;

    // sm_ready driver. In stall mode, each issue is held off for 3 cycles and
    // the operands must stay put while stalled.
    logic        stall_mode  = 1'b0;
    logic        ready_level = 1'b1;
    int          stall_cnt   = 0;
    int          stall_bad   = 0;
    logic [81:0] held_a      = '0;
    logic [81:0] held_b      = '0;

    initial sm_ready = 1'b1;
    always @(negedge clk) begin
        if (stall_mode) begin
            if (sm_valid) begin
                if (stall_cnt == 0) begin
                    held_a = sm_a;
                    held_b = sm_b;
                end else if (sm_a !== held_a || sm_b !== held_b) begin
                    stall_bad = stall_bad + 1;
                end
                if (stall_cnt < 3) begin
                    sm_ready  = 1'b0;
                    stall_cnt = stall_cnt + 1;
                end else begin
                    sm_ready = 1'b1;
                end
            end else begin
                stall_cnt = 0;
                sm_ready  = 1'b0;
            end
        end else begin
            stall_cnt = 0;
            sm_ready  = ready_level;
        end
    end

    task automatic check(input string tag, input logic [326:0] obs, input logic [326:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Pulse start with the operands and count cycles until res_valid.
    task automatic run_op(input logic [162:0] a, input logic [162:0] b, output int cyc);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (res_valid) break;
        end
        check("res_valid_timeout", 327'(res_valid), 327'(1));
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("busy_after_accept", 327'(busy), 327'(0));
    endtask

    localparam logic [162:0] RA = 163'h3_1415926535_8979323846_2643383279_5028841971;
    localparam logic [162:0] RB = 163'h2_7182818284_5904523536_0287471352_6624977572;
    localparam logic [162:0] RC = 163'h6_0221407600_1380649000_6626070150_2997924580;
    localparam logic [162:0] RD = 163'h1_6180339887_4989484820_4586834365_6381177203;

    int           cyc;
    int           hs0;
    logic [326:0] r0;
    logic [162:0] one163;
    logic         seen;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        res_ready = 1'b0;
        one163    = 163'd1;
        repeat (3) @(negedge clk);
        check("rst_busy", 327'(busy), 327'(0));
        check("rst_sm_valid", 327'(sm_valid), 327'(0));
        check("rst_res_valid", 327'(res_valid), 327'(0));
        check("rst_result", result, 327'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // a=1, b=1, L=1: four handshakes, ten-cycle latency
        hs0 = hs_cnt;
        run_op(163'd1, 163'd1, cyc);
        check("lat_l1", 327'(cyc), 327'(10));
        check("hs_1x1", 327'(hs_cnt - hs0), 327'(4));
        check("res_1x1", result, 327'(1));
        check("p1_1x1", 327'(ov_in1), 327'(1));
        accept();

        // x * x lands in P4
        run_op(163'd2, 163'd2, cyc);
        check("p4_xx", 327'(ov_in4), 327'(1));
        check("p1_xx", 327'(ov_in1), 327'(0));
        check("res_xx", result, 327'(4));
        accept();

        // top coefficient squared lands in P1[162]
        run_op(one163 << 162, one163 << 162, cyc);
        check("p1_top", 327'(ov_in1), 327'(one163 << 162));
        check("res_top", result, 327'(1) << 324);
        accept();

        // random operands with issue stalls and random latency
        stall_mode = 1'b1;
        lat_min    = 1;
        lat_max    = 5;
        run_op(RA, RB, cyc);
        check("res_rand_stall", result, ref_mul(RA, RB));
        check("stall_stable", 327'(stall_bad), 327'(0));
        check("res_top_bits", 327'(result[326:325]), 327'(0));
        stall_mode = 1'b0;
        accept();

        // L=3 latency, then hold the result while a start is pulsed
        lat_min = 3;
        lat_max = 3;
        run_op(RC, RD, cyc);
        check("lat_l3", 327'(cyc), 327'(18));
        r0 = ref_mul(RC, RD);
        check("res_rand_l3", result, r0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            a_in  = RA;
            b_in  = RA;
            @(negedge clk);
            start = 1'b0;
            check("hold_valid", 327'(res_valid), 327'(1));
            check("hold_result", result, r0);
            check("hold_busy", 327'(busy), 327'(1));
        end
        accept();
        repeat (3) @(negedge clk);
        check("start_not_queued", 327'(busy), 327'(0));

        // reset during WAIT of k=2, with the late product arriving in IDLE
        lat_min = 5;
        lat_max = 5;
        hs0     = hs_cnt;
        a_in    = RA;
        b_in    = RB;
        start   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (hs_cnt == hs0 + 3) break;
        end
        check("reach_k2_wait", 327'(hs_cnt - hs0), 327'(3));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_busy", 327'(busy), 327'(0));
        check("mrst_sm_valid", 327'(sm_valid), 327'(0));
        check("mrst_res_valid", 327'(res_valid), 327'(0));
        check("mrst_sm_a", 327'(sm_a), 327'(0));
        check("mrst_sm_b", 327'(sm_b), 327'(0));
        check("mrst_ov1", 327'(ov_in1), 327'(0));
        check("mrst_ov2", 327'(ov_in2), 327'(0));
        check("mrst_result", result, 327'(0));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sm_rvalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("late_rvalid_seen", 327'(seen), 327'(1));
        @(negedge clk);
        check("late_busy", 327'(busy), 327'(0));
        check("late_ov3", 327'(ov_in3), 327'(0));
        check("late_ov4", 327'(ov_in4), 327'(0));

        // a=1, b=1+x: odd half of a is zero
        lat_min = 1;
        lat_max = 1;
        hs0     = hs_cnt;
        run_op(163'd1, 163'd3, cyc);
        check("res_1x3", result, 327'(3));
`ifdef OBS_SKIP_ZERO_EN
        check("hs_1x3", 327'(hs_cnt - hs0), 327'(2));
`else
        check("hs_1x3", 327'(hs_cnt - hs0), 327'(4));
`endif
        accept();

        run_op(RB, RC, cyc);
        check("res_after_rst", result, ref_mul(RB, RC));
        accept();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
